// File: rtl/frame_sync_aligner.sv
// frame_sync_aligner: locks a pixel stream onto frame boundaries, drops
// beats until a start-of-frame is seen and flags line/frame framing errors.
module frame_sync_aligner #(
    parameter int DATA_W      = 64,
    parameter int LINE_BEATS  = 960,
    parameter int FRAME_LINES = 1080
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] pixel_stream_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              start_of_frame_in,
    input  logic              end_of_line_in,
    output logic [DATA_W-1:0] pixel_stream_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              start_of_frame_out,
    output logic              end_of_line_out,
    input  logic              clear_errors,
    output logic [3:0]        error_flags,
    output logic [15:0]       frame_count
);

    localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam int PW = DATA_W + 2;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(FRAME_LINES - 1);

    typedef enum logic {
        SEEK = 1'b0,
        PASS = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [LW-1:0] line_q, line_d;
    logic          expect_sof_q, expect_sof_d;

    logic [3:0]    err_q, err_d;
    logic [15:0]   frames_q, frames_d;
    logic          ready_q, ready_d;
    logic          out_vld_q, out_vld_d;
    logic [PW-1:0] out_q, out_d;
    logic          skid_vld_q, skid_vld_d;
    logic [PW-1:0] skid_q, skid_d;

    logic          in_fire;
    logic          out_fire;
    logic          sof;
    logic          eol;
    logic          at_last;
    logic          fwd;
    logic          force_eol;
    logic          frame_done;
    logic [3:0]    err_set;
    logic [PW-1:0] in_pl;

    assign sof      = start_of_frame_in;
    assign eol      = end_of_line_in;
    assign in_fire  = valid_in & ready_q;
    assign out_fire = out_vld_q & ready_in;
    assign at_last  = (beat_q == LAST_BEAT);
    assign in_pl    = {sof, eol | force_eol, pixel_stream_in};

    // framing state register: FSM state plus beat/line position
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= SEEK;
            beat_q       <= '0;
            line_q       <= '0;
            expect_sof_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            expect_sof_q <= expect_sof_d;
        end
    end

    // next framing state; a start-of-frame always wins over line-end checks
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        line_d       = line_q;
        expect_sof_d = expect_sof_q;
        if (in_fire) begin
            unique case (state_q)
                SEEK: begin
                    if (sof) begin
                        state_d      = PASS;
                        beat_d       = BW'(1);
                        line_d       = '0;
                        expect_sof_d = 1'b0;
                    end
                end
                PASS: begin
                    if (sof) begin
                        beat_d       = BW'(1);
                        line_d       = '0;
                        expect_sof_d = 1'b0;
                    end else if (expect_sof_q) begin
                        state_d      = SEEK;
                        expect_sof_d = 1'b0;
                    end else if (eol && at_last) begin
                        beat_d = '0;
                        if (line_q == LAST_LINE) begin
                            line_d       = '0;
                            expect_sof_d = 1'b1;
                        end else begin
                            line_d = line_q + LW'(1);
                        end
                    end else if (eol || at_last) begin
                        state_d = SEEK;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // per-beat decisions: forward/drop, forced EOL, error and frame events
    always_comb begin
        fwd        = 1'b0;
        force_eol  = 1'b0;
        frame_done = 1'b0;
        err_set    = '0;
        if (in_fire) begin
            unique case (state_q)
                SEEK: fwd = sof;
                PASS: begin
                    if (sof) begin
                        fwd        = 1'b1;
                        err_set[2] = ~expect_sof_q;
                    end else if (expect_sof_q) begin
                        err_set[3] = 1'b1;
                    end else begin
                        fwd = 1'b1;
                        if (eol && at_last) begin
                            frame_done = (line_q == LAST_LINE);
                        end else if (eol) begin
                            err_set[0] = 1'b1;
                        end else if (at_last) begin
                            err_set[1] = 1'b1;
                            force_eol  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // two-entry buffer: output register backed by a skid register
    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (out_fire) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                skid_vld_d = fwd;
                if (fwd) skid_d = in_pl;
            end else begin
                out_vld_d = fwd;
                if (fwd) out_d = in_pl;
            end
        end else if (fwd) begin
            if (out_vld_q) begin
                skid_vld_d = 1'b1;
                skid_d     = in_pl;
            end else begin
                out_vld_d = 1'b1;
                out_d     = in_pl;
            end
        end
        ready_d  = ~skid_vld_d;
        err_d    = (clear_errors ? 4'b0000 : err_q) | err_set;
        frames_d = frames_q + 16'(frame_done);
    end

    // buffer, ready, sticky flags and frame counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= '0;
            frames_q   <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            frames_q   <= frames_d;
        end
    end

    assign ready_out          = ready_q;
    assign valid_out          = out_vld_q;
    assign start_of_frame_out = out_q[PW-1];
    assign end_of_line_out    = out_q[PW-2];
    assign pixel_stream_out   = out_q[DATA_W-1:0];
    assign error_flags        = err_q;
    assign frame_count        = frames_q;

endmodule

// File: tb/tb_frame_sync_aligner.sv
// tb_frame_sync_aligner: scenario tasks plus randomized framing streams
// checked against a frame-position reference model.
module tb_frame_sync_aligner;

    localparam int DW = 64;
    localparam int LB = 4;
    localparam int FL = 2;

    typedef struct packed {
        logic          sof;
        logic          eol;
        logic [DW-1:0] data;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] pixel_stream_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic          start_of_frame_in = 1'b0;
    logic          end_of_line_in = 1'b0;
    logic [DW-1:0] pixel_stream_out;
    logic          valid_out;
    logic          ready_in = 1'b0;
    logic          start_of_frame_out;
    logic          end_of_line_out;
    logic          clear_errors = 1'b0;
    logic [3:0]    error_flags;
    logic [15:0]   frame_count;

    int    n_chk = 0;
    int    n_pass = 0;
    beat_t stim_q[$];
    beat_t exp_q[$];
    beat_t got_q[$];
    logic [3:0] m_err;
    int    m_frames;

    frame_sync_aligner #(
        .DATA_W(DW),
        .LINE_BEATS(LB),
        .FRAME_LINES(FL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pixel_stream_in(pixel_stream_in),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .start_of_frame_in(start_of_frame_in),
        .end_of_line_in(end_of_line_in),
        .pixel_stream_out(pixel_stream_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .start_of_frame_out(start_of_frame_out),
        .end_of_line_out(end_of_line_out),
        .clear_errors(clear_errors),
        .error_flags(error_flags),
        .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (!reset && valid_out && ready_in)
            got_q.push_back(beat_t'({start_of_frame_out, end_of_line_out,
                                     pixel_stream_out}));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic beat_t mk(input logic s, input logic e,
                                 input logic [DW-1:0] d);
        return beat_t'({s, e, d});
    endfunction

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic add_frame(input logic [DW-1:0] base);
        for (int i = 0; i < LB * FL; i++)
            stim_q.push_back(mk(i == 0, (i % LB) == LB - 1, base + DW'(i)));
    endtask

    // k = index of the next beat within the current frame
    task automatic model_run();
        bit    synced = 0;
        int    k = 0;
        beat_t b;
        exp_q.delete();
        m_err = 4'b0000;
        m_frames = 0;
        foreach (stim_q[i]) begin
            b = stim_q[i];
            if (!synced) begin
                if (b.sof) begin
                    exp_q.push_back(b);
                    synced = 1;
                    k = 1;
                end
            end else if (b.sof) begin
                if (k != LB * FL) m_err[2] = 1'b1;
                exp_q.push_back(b);
                k = 1;
            end else if (k == LB * FL) begin
                m_err[3] = 1'b1;
                synced = 0;
            end else if (k % LB == LB - 1) begin
                if (!b.eol) m_err[1] = 1'b1;
                b.eol = 1'b1;
                exp_q.push_back(b);
                k++;
                if (!stim_q[i].eol) synced = 0;
                else if (k == LB * FL) m_frames++;
            end else begin
                exp_q.push_back(b);
                if (b.eol) begin
                    m_err[0] = 1'b1;
                    synced = 0;
                end else begin
                    k++;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        clear_errors = 1'b0;
        start_of_frame_in = 1'b0;
        end_of_line_in = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1 got_q.delete();
    endtask

    task automatic send_range(input int lo, input int hi, input bit rnd);
        for (int i = lo; i < hi; i++) begin
            int t = 0;
            valid_in = 1'b1;
            {start_of_frame_in, end_of_line_in, pixel_stream_in} = stim_q[i];
            if (rnd) ready_in = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            while (!ready_out && t < 100) begin
                @(posedge clock);
                #1 if (rnd) ready_in = ($urandom_range(0, 2) != 0);
                @(negedge clock);
                t++;
            end
            if (!ready_out) begin
                n_chk++;
                $display("FAIL send_stall beat %0d: ready_out=%b, required 1",
                         i, ready_out);
                @(posedge clock);
                #1 valid_in = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        while (got_q.size() < exp_q.size() && t < 100) begin
            @(posedge clock);
            #1 t++;
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_chk++;
        if ({valid_out, ready_out, start_of_frame_out, end_of_line_out,
             pixel_stream_out, error_flags, frame_count} !== '0)
            $display("FAIL reset_outputs: vo=%b ro=%b sof=%b eol=%b px=%h err=%b fc=%0d, required all 0",
                     valid_out, ready_out, start_of_frame_out,
                     end_of_line_out, pixel_stream_out, error_flags,
                     frame_count);
        else n_pass++;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if (ready_out !== 1'b0)
            $display("FAIL ready_before_edge: got %b, required 0", ready_out);
        else n_pass++;
        @(posedge clock);
        #1;
        n_chk++;
        if (ready_out !== 1'b1)
            $display("FAIL ready_after_edge: got %b, required 1", ready_out);
        else n_pass++;
    endtask

    task automatic test_latency();
        do_reset();
        ready_in = 1'b1;
        valid_in = 1'b1;
        {start_of_frame_in, end_of_line_in, pixel_stream_in} =
            mk(1'b1, 1'b0, 64'h55);
        @(posedge clock);
        #1 valid_in = 1'b0;
        @(negedge clock);
        n_chk++;
        if ({valid_out, start_of_frame_out, pixel_stream_out} !== {2'b11, 64'h55})
            $display("FAIL latency1: vo=%b sof=%b px=%h, required 1 1 55",
                     valid_out, start_of_frame_out, pixel_stream_out);
        else n_pass++;
        @(negedge clock);
        n_chk++;
        if (valid_out !== 1'b0)
            $display("FAIL latency_consumed: vo=%b, required 0", valid_out);
        else n_pass++;
    endtask

    task automatic test_frame();
        do_reset();
        stim_q.delete();
        stim_q.push_back(mk(1'b0, 1'b0, 64'hA));
        stim_q.push_back(mk(1'b0, 1'b0, 64'hB));
        add_frame(64'h100);
        model_run();
        ready_in = 1'b1;
        send_range(0, stim_q.size(), 1'b0);
        drain();
        n_chk++;
        if (got_q.size() != exp_q.size())
            $display("FAIL frame_count_beats: got %0d, required %0d",
                     got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL frame_beat %0d: got %h, required %h",
                         i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_chk++;
        if (error_flags !== m_err || frame_count !== 16'(m_frames))
            $display("FAIL frame_status: err=%b fc=%0d, required err=%b fc=%0d",
                     error_flags, frame_count, m_err, m_frames);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        beat_t held;
        do_reset();
        stim_q.delete();
        add_frame(64'h200);
        model_run();
        ready_in = 1'b0;
        send_range(0, 2, 1'b0);
        held = exp_q[0];
        repeat (5) begin
            @(negedge clock);
            n_chk++;
            if (ready_out !== 1'b0 || valid_out !== 1'b1 ||
                {start_of_frame_out, end_of_line_out, pixel_stream_out} !== held)
                $display("FAIL bp_hold: ro=%b vo=%b out=%h, required 0 1 %h",
                         ready_out, valid_out,
                         {start_of_frame_out, end_of_line_out, pixel_stream_out},
                         held);
            else n_pass++;
        end
        @(posedge clock);
        #1 ready_in = 1'b1;
        send_range(2, stim_q.size(), 1'b0);
        drain();
        n_chk++;
        if (got_q.size() != exp_q.size())
            $display("FAIL bp_count: got %0d, required %0d",
                     got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL bp_beat %0d: got %h, required %h",
                         i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_chk++;
        if (frame_count !== 16'(m_frames))
            $display("FAIL bp_frames: got %0d, required %0d",
                     frame_count, m_frames);
        else n_pass++;
    endtask

    task automatic test_short_line();
        do_reset();
        stim_q.delete();
        for (int i = 0; i < LB; i++)
            stim_q.push_back(mk(i == 0, i == LB - 1, 64'h300 + DW'(i)));
        stim_q.push_back(mk(1'b0, 1'b0, 64'h310));
        stim_q.push_back(mk(1'b0, 1'b0, 64'h311));
        stim_q.push_back(mk(1'b0, 1'b1, 64'h312));
        stim_q.push_back(mk(1'b0, 1'b0, 64'h320));
        stim_q.push_back(mk(1'b0, 1'b1, 64'h321));
        add_frame(64'h400);
        model_run();
        ready_in = 1'b1;
        send_range(0, stim_q.size(), 1'b0);
        drain();
        n_chk++;
        if (got_q.size() != exp_q.size())
            $display("FAIL short_count: got %0d, required %0d",
                     got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL short_beat %0d: got %h, required %h",
                         i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_chk++;
        if (error_flags !== m_err || frame_count !== 16'(m_frames))
            $display("FAIL short_status: err=%b fc=%0d, required err=%b fc=%0d",
                     error_flags, frame_count, m_err, m_frames);
        else n_pass++;
    endtask

    task automatic test_long_early();
        do_reset();
        stim_q.delete();
        for (int i = 0; i < LB; i++)
            stim_q.push_back(mk(i == 0, 1'b0, 64'h500 + DW'(i)));
        for (int i = 0; i < LB + 2; i++)
            stim_q.push_back(mk(i == 0, i == LB - 1, 64'h600 + DW'(i)));
        add_frame(64'h700);
        model_run();
        ready_in = 1'b1;
        send_range(0, stim_q.size(), 1'b0);
        drain();
        n_chk++;
        if (got_q.size() != exp_q.size())
            $display("FAIL long_count: got %0d, required %0d",
                     got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL long_beat %0d: got %h, required %h",
                         i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_chk++;
        if (error_flags !== m_err || frame_count !== 16'(m_frames))
            $display("FAIL long_status: err=%b fc=%0d, required err=%b fc=%0d",
                     error_flags, frame_count, m_err, m_frames);
        else n_pass++;
    endtask

    task automatic test_missing_sof_clear();
        do_reset();
        stim_q.delete();
        add_frame(64'h800);
        stim_q.push_back(mk(1'b0, 1'b0, 64'h8FF));
        model_run();
        ready_in = 1'b1;
        send_range(0, stim_q.size(), 1'b0);
        drain();
        n_chk++;
        if (got_q.size() != exp_q.size())
            $display("FAIL msof_count: got %0d, required %0d",
                     got_q.size(), exp_q.size());
        else n_pass++;
        n_chk++;
        if (error_flags !== m_err || frame_count !== 16'(m_frames))
            $display("FAIL msof_status: err=%b fc=%0d, required err=%b fc=%0d",
                     error_flags, frame_count, m_err, m_frames);
        else n_pass++;
        clear_errors = 1'b1;
        @(posedge clock);
        #1 clear_errors = 1'b0;
        n_chk++;
        if (error_flags !== 4'b0000 || frame_count !== 16'(m_frames))
            $display("FAIL clear: err=%b fc=%0d, required err=0000 fc=%0d",
                     error_flags, frame_count, m_frames);
        else n_pass++;
        valid_in = 1'b1;
        {start_of_frame_in, end_of_line_in, pixel_stream_in} =
            mk(1'b1, 1'b0, 64'h900);
        @(posedge clock);
        #1 {start_of_frame_in, end_of_line_in, pixel_stream_in} =
            mk(1'b0, 1'b1, 64'h901);
        clear_errors = 1'b1;
        @(posedge clock);
        #1 valid_in = 1'b0;
        clear_errors = 1'b0;
        n_chk++;
        if (error_flags !== 4'b0001)
            $display("FAIL clear_vs_set: err=%b, required 0001", error_flags);
        else n_pass++;
        do_reset();
        ready_in = 1'b0;
        stim_q.delete();
        add_frame(64'hA00);
        send_range(0, 2, 1'b0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (valid_out !== 1'b0 || ready_out !== 1'b0 || frame_count !== 16'd0)
            $display("FAIL reset_mid: vo=%b ro=%b fc=%0d, required 0 0 0",
                     valid_out, ready_out, frame_count);
        else n_pass++;
        @(posedge clock);
        #1 reset = 1'b0;
        ready_in = 1'b1;
        got_q.delete();
        repeat (4) @(posedge clock);
        #1;
        n_chk++;
        if (got_q.size() != 0)
            $display("FAIL reset_no_emit: got %0d beats, required 0",
                     got_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            do_reset();
            stim_q.delete();
            for (int f = 0; f < 5; f++) begin
                if ($urandom_range(0, 4) == 0)
                    stim_q.push_back(mk(1'b0, 1'($urandom_range(0, 1)), rnd64()));
                for (int i = 0; i < LB * FL; i++) begin
                    logic s;
                    logic e;
                    s = (i == 0);
                    e = ((i % LB) == LB - 1);
                    if ($urandom_range(0, 14) == 0) e = ~e;
                    if ($urandom_range(0, 19) == 0) s = ~s;
                    stim_q.push_back(mk(s, e, rnd64()));
                end
            end
            model_run();
            send_range(0, stim_q.size(), 1'b1);
            drain();
            n_chk++;
            if (got_q.size() != exp_q.size())
                $display("FAIL rand%0d_count: got %0d, required %0d",
                         r, got_q.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_chk++;
                if (got_q[i] !== exp_q[i])
                    $display("FAIL rand%0d_beat %0d: got %h, required %h",
                             r, i, got_q[i], exp_q[i]);
                else n_pass++;
            end
            n_chk++;
            if (error_flags !== m_err || frame_count !== 16'(m_frames))
                $display("FAIL rand%0d_status: err=%b fc=%0d, required err=%b fc=%0d",
                         r, error_flags, frame_count, m_err, m_frames);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frame();
        test_backpressure();
        test_short_line();
        test_long_early();
        test_missing_sof_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_sync_aligner.md
FRAME_SYNC_ALIGNER -- requirements
Module: frame_sync_aligner

Interface
REQ-001 SHALL have parameter DATA_W, default 64, pixel beat width.
REQ-002 SHALL have parameter LINE_BEATS, default 960, beats per line (min 2).
REQ-003 SHALL have parameter FRAME_LINES, default 1080, lines per frame (min 2).
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports pixel_stream_in  input  DATA_W, valid_in  input  1, ready_out  output  1, start_of_frame_in  input  1, end_of_line_in  input  1: upstream stream from the keystone correction stage.
REQ-007 SHALL have ports pixel_stream_out  output  DATA_W, valid_out  output  1, ready_in  input  1, start_of_frame_out  output  1, end_of_line_out  output  1: downstream stream.
REQ-008 SHALL have port clear_errors  input  1  clears error flags.
REQ-009 SHALL have port error_flags  output  4  sticky: [0] short line, [1] long line, [2] early SOF, [3] missing SOF.
REQ-010 SHALL have port frame_count  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-011 Input transfer SHALL occur when valid_in and ready_out are both 1; output transfer SHALL occur when valid_out and ready_in are both 1.
REQ-012 SHALL contain a 2-entry buffer (output register + skid register); ready_out SHALL be registered and equal 0 exactly when the skid entry is occupied.
REQ-013 A forwarded beat accepted into an empty buffer SHALL appear on valid_out the next cycle (latency 1); order SHALL be preserved; data, SOF, EOL travel together.
REQ-014 valid_out and payload SHALL remain stable while valid_out=1 and ready_in=0.
REQ-015 Simultaneous input and output transfer SHALL not change buffer occupancy; ready_in held 0 SHALL fill the buffer after 2 accepted beats and drop ready_out the cycle after the second.
REQ-016 State machine SHALL have states SEEK, PASS; reset state SEEK.
REQ-017 SEEK: every accepted beat with start_of_frame_in=0 SHALL be dropped (never enters buffer); a beat with start_of_frame_in=1 SHALL be forwarded, set beat_cnt=1, line_cnt=0, go PASS.
REQ-018 PASS: beats SHALL be forwarded; beat_cnt increments per accepted beat; at a correct line end (end_of_line_in=1 with beat_cnt=LINE_BEATS-1) beat_cnt->0, line_cnt increments.
REQ-019 Short line: end_of_line_in=1 with beat_cnt<LINE_BEATS-1 SHALL forward the beat, set error_flags[0], go SEEK.
REQ-020 Long line: beat_cnt=LINE_BEATS-1 with end_of_line_in=0 SHALL forward the beat with end_of_line_out forced 1, set error_flags[1], go SEEK.
REQ-021 Early SOF: start_of_frame_in=1 in PASS when not at a frame start SHALL set error_flags[2], forward the beat as a new frame start (beat_cnt=1, line_cnt=0), stay PASS; frame_count not incremented.
REQ-022 Correct EOL on line_cnt=FRAME_LINES-1 SHALL increment frame_count and set line_cnt=0, expecting SOF on the next beat.
REQ-023 Missing SOF: first beat after a complete frame with start_of_frame_in=0 SHALL be dropped, set error_flags[3], go SEEK.
REQ-024 If short-line and early-SOF conditions coincide, early SOF SHALL take precedence (REQ-021) and error_flags[0] SHALL not be set.
REQ-025 error_flags bits SHALL be sticky; clear_errors=1 SHALL clear all bits next edge; a new error on the same edge as clear_errors SHALL win (bit set).
REQ-026 A single-beat frame/line combination SHALL obey REQ-017..020 unchanged (SOF and EOL may coincide on one beat).

Reset
REQ-027 While reset=1: valid_out=0, ready_out=0, start_of_frame_out=0, end_of_line_out=0, pixel_stream_out=0, error_flags=0, frame_count=0, buffer empty, state SEEK.
REQ-028 ready_out SHALL rise on the first clock edge after reset deasserts.
REQ-029 Reset asserted mid-frame SHALL discard buffered beats immediately; no partial beat emitted after release.

Verification (LINE_BEATS=4, FRAME_LINES=2)
REQ-030 Beats 0xA,0xB (no SOF) then SOF frame of 8 beats, EOL on beats 4,8, ready_in=1 -> 0xA,0xB dropped; 8 beats out, latency 1, frame_count=1, error_flags=0.
REQ-031 Same frame with ready_in=0 for 5 cycles mid-line -> ready_out low after 2 beats buffered; no data lost/duplicated; output order identical.
REQ-032 EOL on beat 3 of line 1 -> beat 3 out with EOL, error_flags=0b0001, next beats dropped until SOF.
REQ-033 Beat 4 without EOL -> end_of_line_out=1 on beat 4, error_flags=0b0010; SOF mid-line 2 -> error_flags[2]=1, frame restarts, frame_count unchanged.
REQ-034 Complete frame then non-SOF beat -> dropped, error_flags=0b1000; clear_errors pulse -> 0b0000; reset mid-frame with 2 beats buffered -> valid_out=0 immediately, frame_count=0.
